// File: rtl/mestpro_mem_arbiter_pkg.sv
// rtl/mestpro_mem_arbiter_pkg.sv - shared sizes, FSM encodings and port ids for the memory arbiter
// Purpose: constants shared by the arbiter top, its round-robin helper and the bench.
// Contents: ADDR_BITS, DATA_BITS, MEM_SIZE, ROM_SIZE, state_t (ST_IDLE..ST_FAULT), PORT_IF/PORT_LS.
package mestpro_mem_arbiter_pkg;

    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 8;
    localparam int MEM_SIZE  = 128;
    localparam int ROM_SIZE  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    // Port ids double as bit positions in the request/grant vectors.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mestpro_mem_arbiter_rr_arb2.sv
// rtl/mestpro_mem_arbiter_rr_arb2.sv - combinational two-way round-robin grant
// Purpose: pick one of two requesters, favouring the one not granted last.
// Ports: req[1:0] (bit0 fetch, bit1 load/store), last (port id granted last), gnt[1:0] one-hot.
module mestpro_mem_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    import mestpro_mem_arbiter_pkg::*;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mestpro_mem_arbiter.sv
// rtl/mestpro_mem_arbiter.sv - fetch / load-store arbiter and sequencer for the single-port memory
// Purpose: serialise fetch and load/store requests onto one memory, return one ack per transaction.
// Ports: CLK, RESET (async, active high); if_req/if_addr -> if_ack/if_rdata;
//        ls_req/ls_we/ls_addr/ls_wdata -> ls_ack/ls_rdata/ls_err;
//        mem_cs/mem_we/mem_addr/mem_wdat to the memory, mem_rdat/mem_err back from it.
module mestpro_mem_arbiter #(
    parameter int ADDR_BITS = mestpro_mem_arbiter_pkg::ADDR_BITS,
    parameter int DATA_BITS = mestpro_mem_arbiter_pkg::DATA_BITS,
    parameter int MEM_SIZE  = mestpro_mem_arbiter_pkg::MEM_SIZE,
    parameter int ROM_SIZE  = mestpro_mem_arbiter_pkg::ROM_SIZE
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    output logic                 if_ack,
    output logic [DATA_BITS-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [ADDR_BITS-1:0] ls_addr,
    input  logic [DATA_BITS-1:0] ls_wdata,
    output logic                 ls_ack,
    output logic [DATA_BITS-1:0] ls_rdata,
    output logic                 ls_err,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdat,
    input  logic [DATA_BITS-1:0] mem_rdat,
    input  logic                 mem_err
);
    import mestpro_mem_arbiter_pkg::*;

    localparam logic [ADDR_BITS:0] MEM_LIMIT = MEM_SIZE[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] ROM_LIMIT = ROM_SIZE[ADDR_BITS:0];

    state_t                 state_q, state_d;
    logic                   last_q, last_d;
    logic                   cmd_port_q, cmd_port_d;
    logic                   cmd_zero_q, cmd_zero_d;   // response data forced to 0
    logic                   mem_cs_q, mem_cs_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]   mem_wdat_q, mem_wdat_d;
    logic                   if_ack_q, if_ack_d;
    logic                   ls_ack_q, ls_ack_d;
    logic                   fault_q, fault_d;
    logic [DATA_BITS-1:0]   if_hold_q, if_hold_d;
    logic [DATA_BITS-1:0]   ls_hold_q, ls_hold_d;

    logic [1:0]             gnt;
    logic [ADDR_BITS-1:0]   win_addr;
    logic                   win_oor;
    logic                   win_rom_wr;
    logic [DATA_BITS-1:0]   resp_data;

    mestpro_mem_arbiter_rr_arb2 u_arb (
        .req  ({ls_req, if_req}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign win_addr   = gnt[PORT_LS] ? ls_addr : if_addr;
    assign win_oor    = ({1'b0, win_addr} >= MEM_LIMIT);
    assign win_rom_wr = gnt[PORT_LS] && ls_we && ({1'b0, win_addr} < ROM_LIMIT);

    // Registered read data arrives during RESP; out-of-range fetches and
    // rejected ROM stores return zero instead of whatever the macro drives.
    assign resp_data = cmd_zero_q ? '0 : mem_rdat;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cmd_port_d = cmd_port_q;
        cmd_zero_d = cmd_zero_q;
        mem_cs_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        fault_d    = 1'b0;
        if_hold_d  = if_hold_q;
        ls_hold_d  = ls_hold_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    cmd_port_d = gnt[PORT_LS];
                    cmd_zero_d = win_oor || win_rom_wr;
                    if (gnt[PORT_LS] && win_oor) begin
                        // Load/store fault: answer next cycle, never touch the memory.
                        state_d  = ST_FAULT;
                        ls_ack_d = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        // Out-of-range fetches keep the 3-cycle slot but leave CS low.
                        state_d    = ST_ACCESS;
                        mem_cs_d   = !win_oor;
                        mem_we_d   = gnt[PORT_LS] && ls_we && !win_oor;
                        mem_addr_d = win_addr;
                        mem_wdat_d = gnt[PORT_LS] ? ls_wdata : '0;
                    end
                end
            end
            ST_ACCESS: begin
                state_d  = ST_RESP;
                if_ack_d = (cmd_port_q == PORT_IF);
                ls_ack_d = (cmd_port_q == PORT_LS);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = cmd_port_q;
                if (cmd_port_q == PORT_LS) begin
                    ls_hold_d = resp_data;
                end else begin
                    if_hold_d = resp_data;
                end
            end
            ST_FAULT: begin
                state_d   = ST_IDLE;
                last_d    = PORT_LS;
                ls_hold_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            last_q     <= PORT_IF;
            cmd_port_q <= PORT_IF;
            cmd_zero_q <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            fault_q    <= 1'b0;
            if_hold_q  <= '0;
            ls_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cmd_port_q <= cmd_port_d;
            cmd_zero_q <= cmd_zero_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            fault_q    <= fault_d;
            if_hold_q  <= if_hold_d;
            ls_hold_q  <= ls_hold_d;
        end
    end

    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wdat = mem_wdat_q;
    assign if_ack   = if_ack_q;
    assign ls_ack   = ls_ack_q;
    // Acks are only high during RESP/FAULT, so the data mux is a pure data path.
    assign if_rdata = if_ack_q ? resp_data : if_hold_q;
    assign ls_rdata = ls_ack_q ? (fault_q ? '0 : resp_data) : ls_hold_q;
    assign ls_err   = ls_ack_q && (fault_q || mem_err);

endmodule
